bus_arbiter_mux: RTL and testbench

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

---
 rtl/bus_arbiter_mux_pkg.sv | 16 +
 rtl/bus_arbiter_mux_if.sv | 32 +++
 rtl/rr_arbiter_2.sv | 41 ++++
 rtl/bus_arbiter_mux.sv | 74 +++++++
 tb/tb_bus_arbiter_mux.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_mux_pkg.sv
// Shared types and defaults for the two-source valid/ready merging stage.
package bus_arbiter_mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 9;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    typedef enum logic {
        SrcA = 1'b0,
        SrcB = 1'b1
    } src_e;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bundle of the two input streams, the merged output stream and the delivery counter.
interface bus_arbiter_mux_if
    import bus_arbiter_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] dataINA;
    logic             validINA;
    logic             readyINA;
    logic [WIDTH-1:0] dataINB;
    logic             validINB;
    logic             readyINB;
    logic [WIDTH-1:0] dataOUT;
    logic             srcOUT;
    logic             validOUT;
    logic             readyOUT;
    logic [7:0]       countOUT;

    // Environment side: drives the sources and the sink ready.
    modport master (
        output dataINA, validINA, dataINB, validINB, readyOUT,
        input  readyINA, readyINB, dataOUT, srcOUT, validOUT, countOUT
    );

    // Merger side.
    modport slave (
        input  dataINA, validINA, dataINB, validINB, readyOUT,
        output readyINA, readyINB, dataOUT, srcOUT, validOUT, countOUT
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; the winner of a contention is the source not granted last.
module rr_arbiter_2
    import bus_arbiter_mux_pkg::*;
(
    input  logic       clk,
    input  logic       nRst,
    input  logic       reqa,
    input  logic       reqb,
    input  logic       en,
    output logic [1:0] grant
);

    src_e last_q, last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (en) begin
            if (reqa && (!reqb || last_q == SrcB)) begin
                grant = 2'b01;
            end else if (reqb) begin
                grant = 2'b10;
            end
        end
        // Any grant under enable is an accepted transfer, so history moves with it.
        if (grant[0]) begin
            last_d = SrcA;
        end else if (grant[1]) begin
            last_d = SrcB;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            last_q <= SrcB;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Merges two valid/ready streams into one registered output stream tagged with its source.
module bus_arbiter_mux
    import bus_arbiter_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              nRst,
    bus_arbiter_mux_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    src_e             src_q, src_d;
    logic [7:0]       count_q, count_d;
    logic             load;
    logic             take;
    logic             accept;
    logic [1:0]       grant;

    assign load = (state_q == StEmpty) || bus.readyOUT;
    assign take = (state_q == StFull) && bus.readyOUT;

    // Reset gates the enable so neither source sees ready while nRst is low.
    rr_arbiter_2 u_arb (
        .clk   (clk),
        .nRst  (nRst),
        .reqa  (bus.validINA),
        .reqb  (bus.validINB),
        .en    (load && nRst),
        .grant (grant)
    );

    assign accept       = |grant;
    assign bus.readyINA = grant[0];
    assign bus.readyINB = grant[1];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        count_d = count_q;
        if (accept) begin
            state_d = StFull;
            data_d  = grant[1] ? bus.dataINB : bus.dataINA;
            src_d   = grant[1] ? SrcB : SrcA;
        end else if (take) begin
            state_d = StEmpty;
        end
        if (take) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            src_q   <= SrcA;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            count_q <= count_d;
        end
    end

    assign bus.validOUT = (state_q == StFull);
    assign bus.dataOUT  = data_q;
    assign bus.srcOUT   = src_q;
    assign bus.countOUT = count_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: cycle-by-cycle model comparison plus literal spot checks.
module tb_bus_arbiter_mux;
    import bus_arbiter_mux_pkg::*;

    localparam int unsigned W = 9;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(W)) bus ();

    bus_arbiter_mux #(.WIDTH(W)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one output slot, the last winner, and a delivery count.
    bit         m_valid;
    logic [8:0] m_data;
    bit         m_src;
    bit         m_last;
    logic [7:0] m_count;

    initial begin : model
        bit         n_valid, n_src, n_last, e_ra, e_rb, room;
        logic [8:0] n_data;
        logic [7:0] n_count;
        m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_count = '0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_count = '0;
                e_ra = 0; e_rb = 0;
            end else begin
                room = !m_valid || bus.readyOUT;
                e_ra = 0; e_rb = 0;
                if (room) begin
                    if (bus.validINA && bus.validINB) begin
                        if (m_last) e_ra = 1; else e_rb = 1;
                    end else begin
                        e_ra = bus.validINA;
                        e_rb = bus.validINB;
                    end
                end
            end
            chk("m_readyINA", bus.readyINA, e_ra);
            chk("m_readyINB", bus.readyINB, e_rb);
            chk("m_validOUT", bus.validOUT, m_valid);
            chk("m_countOUT", bus.countOUT, m_count);
            if (m_valid) begin
                chk("m_dataOUT", bus.dataOUT, m_data);
                chk("m_srcOUT", bus.srcOUT, m_src);
            end
            n_valid = m_valid; n_data = m_data; n_src = m_src; n_last = m_last; n_count = m_count;
            if (m_valid && bus.readyOUT) begin
                n_count = m_count + 8'd1;
                n_valid = 0;
            end
            if (e_ra || e_rb) begin
                n_valid = 1;
                n_src   = e_rb;
                n_last  = e_rb;
                n_data  = e_rb ? bus.dataINB : bus.dataINA;
            end
            @(posedge clk);
            if (!nRst) begin
                m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_count = '0;
            end else begin
                m_valid = n_valid; m_data = n_data; m_src = n_src; m_last = n_last;
                m_count = n_count;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        chk("rst_validOUT", bus.validOUT, 0);
        chk("rst_dataOUT", bus.dataOUT, 0);
        chk("rst_countOUT", bus.countOUT, 0);
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
    endtask

    task automatic set_in(input bit va, input logic [8:0] da, input bit vb, input logic [8:0] db,
                          input bit rdy);
        bus.validINA = va; bus.dataINA = da;
        bus.validINB = vb; bus.dataINB = db;
        bus.readyOUT = rdy;
    endtask

    initial begin : stim
        set_in(1, 9'h155, 0, 9'h000, 1);
        #1;
        chk("init_readyINA", bus.readyINA, 0);
        chk("init_validOUT", bus.validOUT, 0);
        chk("init_dataOUT", bus.dataOUT, 0);
        chk("init_srcOUT", bus.srcOUT, 0);
        chk("init_countOUT", bus.countOUT, 0);
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;

        // Single source
        #1 chk("single_readyINA", bus.readyINA, 1);
        tick();
        chk("single_dataOUT", bus.dataOUT, 9'h155);
        chk("single_srcOUT", bus.srcOUT, 0);
        chk("single_validOUT", bus.validOUT, 1);
        bus.validINA = 0;
        tick();
        chk("single_count", bus.countOUT, 1);
        chk("single_empty", bus.validOUT, 0);

        // Contention alternates A,B,A,B
        set_in(1, 9'h011, 1, 9'h122, 1);
        do_reset();
        #1;
        chk("cont_readyINA", bus.readyINA, 1);
        chk("cont_readyINB", bus.readyINB, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_dataOUT", bus.dataOUT, (i % 2) ? 9'h122 : 9'h011);
            chk("cont_srcOUT", bus.srcOUT, i % 2);
        end
        chk("cont_count", bus.countOUT, 3);

        // Backpressure
        set_in(1, 9'h0AA, 0, 9'h000, 0);
        do_reset();
        tick();
        set_in(1, 9'h033, 1, 9'h122, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_readyINA", bus.readyINA, 0);
            chk("bp_readyINB", bus.readyINB, 0);
            chk("bp_dataOUT", bus.dataOUT, 9'h0AA);
            tick();
        end
        bus.readyOUT = 1;
        #1;
        chk("bp_rel_readyINB", bus.readyINB, 1);
        chk("bp_rel_readyINA", bus.readyINA, 0);
        tick();
        chk("bp_next_dataOUT", bus.dataOUT, 9'h122);
        chk("bp_next_srcOUT", bus.srcOUT, 1);
        chk("bp_next_count", bus.countOUT, 1);

        // Reset while FULL
        set_in(1, 9'h1FF, 0, 9'h000, 0);
        do_reset();
        tick();
        chk("mid_full_data", bus.dataOUT, 9'h1FF);
        bus.validINA = 0;
        #2 nRst = 1'b0;
        #1;
        chk("mid_validOUT", bus.validOUT, 0);
        chk("mid_dataOUT", bus.dataOUT, 0);
        set_in(1, 9'h011, 1, 9'h122, 1);
        @(posedge clk);
        #1 nRst = 1'b1;
        #1;
        chk("mid_first_grantA", bus.readyINA, 1);
        chk("mid_first_noB", bus.readyINB, 0);
        tick();
        chk("mid_first_src", bus.srcOUT, 0);

        // Idle with readyOUT high
        set_in(0, 9'h000, 0, 9'h000, 1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_validOUT", bus.validOUT, 0);
            chk("idle_count", bus.countOUT, 0);
        end

        // Counter wrap
        set_in(1, 9'h0A5, 0, 9'h000, 1);
        do_reset();
        repeat (257) @(posedge clk);
        #1;
        chk("wrap_256", bus.countOUT, 0);
        tick();
        chk("wrap_257", bus.countOUT, 1);

        set_in(0, 9'h000, 0, 9'h000, 0);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
